// File: rtl/if_bundle_buffer.sv
// Fetch-stage bundle queue between the icache read port and the instruction buffer.
// Optional per-bundle exception fields are built when IF_BUNDLE_EXC_EN is defined.
module if_bundle_buffer #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned INST_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FETCH_WIDTH*ADDR_W-1:0] in_pc,
  input  logic [FETCH_WIDTH*INST_W-1:0] in_inst,
  input  logic [FETCH_WIDTH-1:0]        in_is_branch,
  input  logic [FETCH_WIDTH-1:0]        in_slot_valid,
`ifdef IF_BUNDLE_EXC_EN
  input  logic                          in_excp,
  input  logic [5:0]                    in_ecode,
  output logic                          out_excp,
  output logic [5:0]                    out_ecode,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FETCH_WIDTH*ADDR_W-1:0] out_pc,
  output logic [FETCH_WIDTH*INST_W-1:0] out_inst,
  output logic [FETCH_WIDTH-1:0]        out_is_branch,
  output logic [FETCH_WIDTH-1:0]        out_slot_valid,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [FETCH_WIDTH*ADDR_W-1:0] pc;
    logic [FETCH_WIDTH*INST_W-1:0] inst;
    logic [FETCH_WIDTH-1:0]        is_branch;
    logic [FETCH_WIDTH-1:0]        slot_valid;
`ifdef IF_BUNDLE_EXC_EN
    logic                          excp;
    logic [5:0]                    ecode;
`endif
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             in_entry;
  entry_t             head;
  logic               push;
  logic               pop;

  always_comb begin
    in_entry            = '0;
    in_entry.pc         = in_pc;
    in_entry.inst       = in_inst;
    in_entry.is_branch  = in_is_branch;
    in_entry.slot_valid = in_slot_valid;
`ifdef IF_BUNDLE_EXC_EN
    in_entry.excp       = in_excp;
    in_entry.ecode      = in_ecode;
`endif
  end

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state: flush wins over any handshake in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Head entry, forced to zero while empty so the decoder never sees stale data.
  assign head           = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_pc         = head.pc;
  assign out_inst       = head.inst;
  assign out_is_branch  = head.is_branch;
  assign out_slot_valid = head.slot_valid;
`ifdef IF_BUNDLE_EXC_EN
  assign out_excp       = head.excp;
  assign out_ecode      = head.ecode;
`endif
  assign count          = count_q;

endmodule

// File: tb/tb_if_bundle_buffer.sv
// Bench for if_bundle_buffer: directed vector table, hand sequences and random traffic
// checked against a queue-based reference model.
module tb_if_bundle_buffer;

  localparam int unsigned FW    = 2;
  localparam int unsigned IW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [FW*AW-1:0] pc;
    logic [FW*IW-1:0] inst;
    logic [FW-1:0]    br;
    logic [FW-1:0]    sv;
    logic             excp;
    logic [5:0]       ecode;
  } bundle_t;

  typedef struct {
    logic iv;
    logic ordy;
    int   id;
    int   exp_cnt;
    logic exp_ir;
    int   exp_head;
  } vec_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [FW*AW-1:0] in_pc, out_pc;
  logic [FW*IW-1:0] in_inst, out_inst;
  logic [FW-1:0]    in_is_branch, in_slot_valid, out_is_branch, out_slot_valid;
  logic [$clog2(DEPTH+1)-1:0] count;
`ifdef IF_BUNDLE_EXC_EN
  logic in_excp, out_excp;
  logic [5:0] in_ecode, out_ecode;
`endif

  int checks = 0;
  int errors = 0;
  bundle_t model_q[$];
  bundle_t cur;
  bundle_t prev;
  vec_t    tbl[6];

  always #5 clk = ~clk;

  if_bundle_buffer #(.FETCH_WIDTH(FW), .INST_W(IW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_is_branch(in_is_branch), .in_slot_valid(in_slot_valid),
`ifdef IF_BUNDLE_EXC_EN
    .in_excp(in_excp), .in_ecode(in_ecode), .out_excp(out_excp), .out_ecode(out_ecode),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_is_branch(out_is_branch),
    .out_slot_valid(out_slot_valid), .count(count)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_out();
    logic [255:0] v;
    v = 256'({out_pc, out_inst, out_is_branch, out_slot_valid});
`ifdef IF_BUNDLE_EXC_EN
    v = {v[248:0], out_excp, out_ecode};
`endif
    return v;
  endfunction

  function automatic logic [255:0] pack_exp(input bundle_t b);
    logic [255:0] v;
    v = 256'({b.pc, b.inst, b.br, b.sv});
`ifdef IF_BUNDLE_EXC_EN
    v = {v[248:0], b.excp, b.ecode};
`endif
    return v;
  endfunction

  function automatic bundle_t mk(input int id);
    bundle_t b;
    b.pc    = {32'h1000_0004 + 32'(id * 8), 32'h1000_0000 + 32'(id * 8)};
    b.inst  = {32'(id * 2 + 1), 32'(id * 2)};
    b.br    = 2'(id);
    b.sv    = 2'(id + 1);
    b.excp  = 1'(id);
    b.ecode = 6'(id * 3);
    return b;
  endfunction

  function automatic bundle_t rnd();
    bundle_t b;
    b.pc    = {$urandom, $urandom};
    b.inst  = {$urandom, $urandom};
    b.br    = 2'($urandom);
    b.sv    = 2'($urandom);
    b.excp  = 1'($urandom);
    b.ecode = 6'($urandom);
    return b;
  endfunction

  task automatic drive(input bundle_t b, input logic v);
    cur           = b;
    in_valid      = v;
    in_pc         = b.pc;
    in_inst       = b.inst;
    in_is_branch  = b.br;
    in_slot_valid = b.sv;
`ifdef IF_BUNDLE_EXC_EN
    in_excp       = b.excp;
    in_ecode      = b.ecode;
`endif
  endtask

  // One clock: model follows the queue rules, then every visible output is compared.
  task automatic step();
    bit      push, pop, do_clr;
    bundle_t b;
    push   = (in_valid === 1'b1) && (model_q.size() < DEPTH);
    pop    = (model_q.size() != 0) && (out_ready === 1'b1);
    do_clr = (rst === 1'b1) || (flush === 1'b1);
    b      = cur;
    @(posedge clk);
    if (do_clr) model_q.delete();
    else begin
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(b);
    end
    #1;
    chk("count", 256'(count), 256'(model_q.size()));
    chk("in_ready", 256'(in_ready), 256'(model_q.size() != DEPTH));
    chk("out_valid", 256'(out_valid), 256'(model_q.size() != 0));
    chk("out_data", pack_out(), (model_q.size() != 0) ? pack_exp(model_q[0]) : 256'(0));
  endtask

  initial begin
    bundle_t b;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(mk(0), 1'b0);
    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", 256'(in_ready), 256'(1));
    chk("reset_out_valid", 256'(out_valid), 256'(0));

    // Single push with the first-fetch bundle.
    b.pc = {32'h1c00_0004, 32'h1c00_0000};
    b.inst = {32'h0280_0c21, 32'h0280_1421};
    b.br = 2'b10; b.sv = 2'b11; b.excp = 1'b0; b.ecode = 6'h0;
    out_ready = 1'b1;
    drive(b, 1'b1);
    step();
    chk("single_branch", 256'(out_is_branch), 256'(2'b10));
    chk("single_pc", 256'(out_pc), 256'(64'h1c00_0004_1c00_0000));
    chk("single_inst", 256'(out_inst), 256'(64'h0280_0c21_0280_1421));
    drive(b, 1'b0);
    step();
    chk("single_drained", 256'(count), 256'(0));

    // Fill/backpressure vectors: A, B fill; C waits until A pops.
    tbl[0] = '{1'b1, 1'b0, 1, 1, 1'b1, 1};
    tbl[1] = '{1'b1, 1'b0, 2, 2, 1'b0, 1};
    tbl[2] = '{1'b1, 1'b0, 3, 2, 1'b0, 1};
    tbl[3] = '{1'b1, 1'b1, 3, 1, 1'b1, 2};
    tbl[4] = '{1'b1, 1'b1, 3, 1, 1'b1, 3};
    tbl[5] = '{1'b0, 1'b1, 3, 0, 1'b1, 0};
    for (int i = 0; i < 6; i++) begin
      out_ready = tbl[i].ordy;
      drive(mk(tbl[i].id), tbl[i].iv);
      step();
      chk($sformatf("vec%0d_count", i), 256'(count), 256'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_in_ready", i), 256'(in_ready), 256'(tbl[i].exp_ir));
      chk($sformatf("vec%0d_head", i), pack_out(),
          (tbl[i].exp_head != 0) ? pack_exp(mk(tbl[i].exp_head)) : 256'(0));
    end

    // Steady push+pop at count 1: output lags input by one bundle, pointers wrap.
    out_ready = 1'b0;
    prev = mk(10);
    drive(prev, 1'b1);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(mk(11 + i), 1'b1);
      step();
      chk($sformatf("stream%0d_count", i), 256'(count), 256'(1));
      chk($sformatf("stream%0d_head", i), pack_out(), pack_exp(mk(11 + i)));
    end
    drive(mk(0), 1'b0);
    step();

    // Flush at count 2 while D is offered.
    out_ready = 1'b0;
    drive(mk(20), 1'b1); step();
    drive(mk(21), 1'b1); step();
    flush = 1'b1; out_ready = 1'b1;
    drive(mk(22), 1'b1);
    step();
    flush = 1'b0;
    chk("flush_count", 256'(count), 256'(0));
    chk("flush_out_valid", 256'(out_valid), 256'(0));
    chk("flush_out_zero", pack_out(), 256'(0));
    drive(mk(22), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush_no_d%0d", i), 256'(out_valid), 256'(0));
    end

    // Reset mid-stream with push and pop both active.
    out_ready = 1'b0;
    drive(mk(30), 1'b1); step();
    out_ready = 1'b1; rst = 1'b1;
    drive(mk(31), 1'b1);
    step();
    rst = 1'b0;
    chk("rst_mid_count", 256'(count), 256'(0));
    chk("rst_mid_in_ready", 256'(in_ready), 256'(1));
    chk("rst_mid_out_valid", 256'(out_valid), 256'(0));

`ifdef IF_BUNDLE_EXC_EN
    b = mk(0); b.excp = 1'b1; b.ecode = 6'h08; b.sv = 2'b00;
    drive(b, 1'b1);
    step();
    chk("exc_excp", 256'(out_excp), 256'(1));
    chk("exc_ecode", 256'(out_ecode), 256'(6'h08));
    chk("exc_mask", 256'(out_slot_valid), 256'(2'b00));
    drive(b, 1'b0);
    step();
`endif

    // Random traffic, including occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = 1'($urandom_range(0, 19) == 0);
      rst       = 1'($urandom_range(0, 49) == 0);
      drive(rnd(), 1'($urandom_range(0, 2) != 0));
      step();
    end
    rst = 1'b0; flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
